// File: rtl/imem_arbiter_if.sv
// Instruction-memory port: request and response channels, each valid/ready.
interface imem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_ready;

  // Requester side: issues requests, consumes responses.
  modport master (
    output req_valid, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  // Memory side: accepts requests, produces responses.
  modport slave (
    input  req_valid, req_addr, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/imem_arbiter.sv
// Two-master arbiter onto one imem slave port: round-robin grant with lock
// until handshake, in-order ID FIFO steering responses back to the issuer.
module imem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  imem_arbiter_if.slave                m0,
  imem_arbiter_if.slave                m1,
  imem_arbiter_if.master               s,
  output logic [$clog2(MAX_OUTST):0]   outst_cnt,
  output logic                         err_orphan
);

  localparam int unsigned PTR_W = $clog2(MAX_OUTST);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic               lock_id_q, lock_id_d;
  logic               fifo_q [MAX_OUTST];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_q;

  logic               full, empty;
  logic               gnt_vld, gnt_id;
  logic               push, pop;
  logic               dest;
  logic               orphan;
  logic [ADDR_W-1:0]  gnt_addr;
  logic [DATA_W-1:0]  rsp_data;

  assign full  = (cnt_q == CNT_W'(MAX_OUTST));
  assign empty = (cnt_q == '0);
  assign dest  = fifo_q[rd_ptr_q];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Grant selection, lock tracking and request-channel outputs.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    lock_id_d = lock_id_q;
    gnt_vld   = 1'b0;
    gnt_id    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!full) begin
          if (m0.req_valid && m1.req_valid) begin
            gnt_vld = 1'b1;
            gnt_id  = ptr_q;
          end else if (m0.req_valid) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b0;
          end else if (m1.req_valid) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b1;
          end
        end
        if (gnt_vld && !s.req_ready) begin
          state_d   = LOCKED;
          lock_id_d = gnt_id;
        end
      end
      LOCKED: begin
        gnt_vld = 1'b1;
        gnt_id  = lock_id_q;
        if (s.req_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    push     = gnt_vld && s.req_ready;
    if (push) ptr_d = ~gnt_id;
    gnt_addr = gnt_id ? m1.req_addr : m0.req_addr;
    s.req_valid  = gnt_vld;
    s.req_addr   = gnt_addr;
    m0.req_ready = gnt_vld && !gnt_id && s.req_ready;
    m1.req_ready = gnt_vld &&  gnt_id && s.req_ready;
  end

  // Response steering: FIFO head picks the destination; orphans are drained.
  always_comb begin
    rsp_data      = s.resp_data;
    m0.resp_data  = rsp_data;
    m1.resp_data  = rsp_data;
    m0.resp_valid = s.resp_valid && !empty && !dest;
    m1.resp_valid = s.resp_valid && !empty &&  dest;
    if (empty) s.resp_ready = s.resp_valid;
    else       s.resp_ready = dest ? m1.resp_ready : m0.resp_ready;
    pop    = s.resp_valid && s.resp_ready && !empty;
    orphan = s.resp_valid && empty;
  end

  // Priority pointer and locked grant ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= 1'b0;
      lock_id_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      lock_id_q <= lock_id_d;
    end
  end

  // In-order ID FIFO of granted masters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MAX_OUTST); i++) fifo_q[i] <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= gnt_id;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Outstanding-request counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (push && !pop) cnt_q <= cnt_q + CNT_W'(1);
    else if (pop && !push) cnt_q <= cnt_q - CNT_W'(1);
  end

  // Orphan-response pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= orphan;
  end

  assign outst_cnt  = cnt_q;
  assign err_orphan = err_q;

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares one instruction-memory slave port between two requesters: m0 = core fetch, m1 = debug/loader.
- Request and response channels each use a valid/ready handshake with the same signal set as the imem interface.
- Arbitrates requests round-robin with a grant lock, tracks outstanding requests in an in-order ID FIFO, and steers each response back to the master that issued it.
- Sits between the fetch unit/debug module and the imem slave.

Parameters:
- ADDR_W, 32, request address width.
- DATA_W, 32, response data width.
- MAX_OUTST, 4, maximum outstanding requests (FIFO depth). Must be a power of two, ≥2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- m0_req_valid  input  1  master 0 request valid
- m0_req_addr  input  ADDR_W  master 0 request address
- m0_req_ready  output  1  master 0 request accepted
- m0_resp_valid  output  1  master 0 response valid
- m0_resp_data  output  DATA_W  master 0 response data
- m0_resp_ready  input  1  master 0 can take response
- m1_req_valid, m1_req_addr, m1_req_ready, m1_resp_valid, m1_resp_data, m1_resp_ready: same as m0, for master 1
- s_req_valid  output  1  request valid to imem slave
- s_req_addr  output  ADDR_W  request address to imem slave
- s_req_ready  input  1  slave accepts request
- s_resp_valid  input  1  slave response valid
- s_resp_data  input  DATA_W  slave response data
- s_resp_ready  output  1  arbiter can take response
- outst_cnt  output  $clog2(MAX_OUTST)+1  outstanding requests
- err_orphan  output  1  one-cycle pulse: response received with no outstanding request

Interface:
- One clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
Reset values:
- s_req_valid=0, m*_req_ready=0, m*_resp_valid=0, s_resp_ready=0, outst_cnt=0, err_orphan=0.
- FIFO is empty, priority pointer=0 (m0 favoured), state=IDLE.

Request FSM:
- IDLE:
  - If the FIFO is full, no grant: s_req_valid=0 and both req_ready=0.
  - Otherwise pick a requester. If only one is valid, grant it. If both are valid, grant the one the pointer favours.
  - s_req_valid and s_req_addr are driven combinationally from the granted master, in the same cycle.
  - Granted master's req_ready = s_req_ready. Other master's req_ready=0.
  - If the handshake completes this cycle: push the grant ID, flip the pointer to favour the other master, stay IDLE.
  - Otherwise: latch the grant ID and go to LOCKED.
- LOCKED:
  - The grant is held regardless of the other master's valid.
  - Requester must keep valid and addr stable until accepted.
  - On handshake: push ID, flip pointer, go to IDLE.
  - Arbiter never drops s_req_valid once asserted until the handshake.
- Zero added latency: a request can be accepted in the cycle it is presented.

Response path:
- Head of FIFO selects the destination master.
- dest resp_valid = s_resp_valid and FIFO not empty; dest resp_data = s_resp_data.
- Non-dest resp_valid=0.
- s_resp_ready = dest resp_ready when the FIFO is non-empty.
- Pop the FIFO on s_resp_valid & s_resp_ready & !empty.
- Responses are assumed in-order by the slave protocol. No reordering.

Boundaries:
- Push and pop in the same cycle: outst_cnt unchanged, FIFO pointers wrap modulo MAX_OUTST.
- Full: a new grant is blocked until a pop frees an entry. No same-cycle bypass: a pop in the full cycle enables requests the next cycle.
- Already-LOCKED grant when the FIFO becomes full: this cannot occur, because LOCKED is only entered when not full and the handshake is the only push.
- Response while the FIFO is empty:
  - s_resp_ready=1 (drain).
  - err_orphan pulses for one cycle.
  - Data is not forwarded to either master.
- Response backpressure from dest holds the slave response. It does not affect the request path.
- rst_n asserted mid-transaction: all state is cleared immediately. In-flight responses are lost. Slave and masters must be reset together.
- outst_cnt never exceeds MAX_OUTST.

Test Plan:
- Single master: m0 issues addr 0x100 with s_req_ready=1. Expect s_req_addr=0x100 in the same cycle, then m0_resp_valid with data 0xDEAD0100 when the slave responds. m1_resp_valid stays 0.
- Contention: both masters request every cycle, s_req_ready=1. Expect grants to alternate m0, m1, m0, m1 over 4 cycles, addresses matching, outst_cnt reaching 4 with responses withheld.
- Grant lock: m0 requests 0x200 with s_req_ready=0 for 3 cycles while m1 is also valid. Expect s_req_addr held at 0x200 and m1_req_ready=0 throughout. m0 is accepted in cycle 4, then m1 is granted next.
- Full FIFO: 4 requests outstanding. Expect both req_ready=0 and s_req_valid=0. After one response pops, a new request is accepted on the following cycle and outst_cnt returns to 4.
- Routing plus backpressure: order m1, m0, m1 with m1_resp_ready=0 for 2 cycles. Expect the first response held on s_resp (s_resp_ready=0), then delivered to m1, then m0, then m1, with data intact.
- Orphan and reset: s_resp_valid with an empty FIFO gives a one-cycle err_orphan pulse and no master valid. Asserting rst_n low with 3 outstanding gives outst_cnt=0 and all valids 0 asynchronously.
